// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - opcode constants, argument-count lookup and decoder state encoding for oled_rx
package oled_pkg;

    localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
    localparam logic [7:0] OP_COL_ADDR    = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_COM_PINS    = 8'hDA;
    localparam logic [7:0] OP_VCOMH       = 8'hDB;

    typedef enum logic {
        DEC_OP  = 1'b0,
        DEC_ARG = 1'b1
    } dec_state_e;

    // Number of argument bytes that follow an opcode; 0 means single-byte command
    function automatic logic [1:0] arg_count(input logic [7:0] op);
        logic [1:0] n;
        n = 2'd0;
        case (op)
            OP_ADDR_MODE, OP_CONTRAST, OP_MUX_RATIO, OP_DISP_OFFSET, OP_CLK_DIV,
            OP_PRECHARGE, OP_COM_PINS, OP_VCOMH, OP_CHARGE_PUMP: n = 2'd1;
            OP_COL_ADDR, OP_PAGE_ADDR:                           n = 2'd2;
            default:                                             n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/oled_rx_fb.sv
// rtl/oled_rx_fb.sv - framebuffer RAM, one write port and one registered read port
module oled_rx_fb #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Write and registered read; a colliding read sees the pre-write contents
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/oled_rx.sv
// rtl/oled_rx.sv - SPI OLED controller receiver with command decoder and framebuffer; OLED_RX_ADDR_WINDOW_EN enables 0x21/0x22 windows
module oled_rx
    import oled_pkg::*;
#(
    parameter int FB_BYTES = 1024,
    parameter int COLS     = 128,
    parameter int PAGES    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        oled_sck,
    input  logic                        oled_mosi,
    input  logic                        oled_dc,
    input  logic                        oled_cs,
    input  logic [$clog2(FB_BYTES)-1:0] rd_addr,
    output logic [7:0]                  rd_data,
    output logic                        byte_valid,
    output logic [7:0]                  byte_data,
    output logic                        byte_dc,
    output logic                        display_on,
    output logic [7:0]                  contrast
);

    localparam int AW = $clog2(FB_BYTES);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    logic [1:0]    sck_sync_q, mosi_sync_q, dc_sync_q, cs_sync_q;
    logic          sck_prev_q;
    logic          sck_rise;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          byte_valid_q;
    logic [7:0]    byte_data_q;
    logic          byte_dc_q;

    dec_state_e    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [7:0]    op_q, op_d;
    logic          disp_q, disp_d;
    logic [7:0]    contrast_q, contrast_d;
    logic [7:0]    mode_q, mode_d;
    logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic          fb_we;
    logic [AW-1:0] fb_waddr;

`ifdef OLED_RX_ADDR_WINDOW_EN
    function automatic logic [CW-1:0] clamp_col(input logic [7:0] v);
        return (int'(v) > COLS - 1) ? CW'(COLS - 1) : CW'(v);
    endfunction

    function automatic logic [PW-1:0] clamp_page(input logic [7:0] v);
        return (int'(v) > PAGES - 1) ? PW'(PAGES - 1) : PW'(v);
    endfunction
`endif

    // Two-flop synchronizers for all SPI pins; sck and cs reset to their idle-high level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= 2'b11;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            dc_sync_q   <= 2'b00;
            sck_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], oled_sck};
            cs_sync_q   <= {cs_sync_q[0], oled_cs};
            mosi_sync_q <= {mosi_sync_q[0], oled_mosi};
            dc_sync_q   <= {dc_sync_q[0], oled_dc};
            sck_prev_q  <= sck_sync_q[1];
        end
    end

    assign sck_rise = !sck_prev_q && sck_sync_q[1] && !cs_sync_q[1];

    // Bit assembly: shift on each sck rise, strobe the completed byte the cycle after the 8th edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_dc_q    <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            if (cs_sync_q[1]) begin
                bit_cnt_q <= 3'd0;
                shift_q   <= 8'h00;
            end else if (sck_rise) begin
                shift_q   <= {shift_q[6:0], mosi_sync_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_q <= 1'b1;
                    byte_data_q  <= {shift_q[6:0], mosi_sync_q[1]};
                    byte_dc_q    <= dc_sync_q[1];
                end
            end
        end
    end

    // Decoder and pointer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DEC_OP;
            cnt_q        <= 2'd0;
            op_q         <= 8'h00;
            disp_q       <= 1'b0;
            contrast_q   <= 8'h7F;
            mode_q       <= 8'h00;
            col_q        <= '0;
            page_q       <= '0;
            col_start_q  <= '0;
            col_end_q    <= CW'(COLS - 1);
            page_start_q <= '0;
            page_end_q   <= PW'(PAGES - 1);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            disp_q       <= disp_d;
            contrast_q   <= contrast_d;
            mode_q       <= mode_d;
            col_q        <= col_d;
            page_q       <= page_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
        end
    end

    // Next-state: data bytes write and advance the pointer; command bytes drive the opcode/argument decoder
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        disp_d       = disp_q;
        contrast_d   = contrast_q;
        mode_d       = mode_q;
        col_d        = col_q;
        page_d       = page_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        fb_we        = 1'b0;

        if (byte_valid_q) begin
            if (byte_dc_q) begin
                fb_we = 1'b1;
                // Every addressing mode value advances horizontally
                case (mode_q)
                    default: begin
                        if (col_q == col_end_q) begin
                            col_d  = col_start_q;
                            page_d = (page_q == page_end_q) ? page_start_q : page_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                endcase
            end else begin
                case (state_q)
                    DEC_OP: begin
                        if (byte_data_q == OP_DISPLAY_ON)  disp_d = 1'b1;
                        if (byte_data_q == OP_DISPLAY_OFF) disp_d = 1'b0;
                        if (arg_count(byte_data_q) != 2'd0) begin
                            state_d = DEC_ARG;
                            cnt_d   = arg_count(byte_data_q);
                            op_d    = byte_data_q;
                        end
                    end
                    DEC_ARG: begin
                        case (op_q)
                            OP_CONTRAST:  contrast_d = byte_data_q;
                            OP_ADDR_MODE: mode_d     = byte_data_q;
`ifdef OLED_RX_ADDR_WINDOW_EN
                            OP_COL_ADDR: begin
                                if (cnt_q == 2'd2) begin
                                    col_start_d = clamp_col(byte_data_q);
                                end else begin
                                    col_end_d = clamp_col(byte_data_q);
                                    col_d     = col_start_q;
                                    page_d    = page_start_q;
                                end
                            end
                            OP_PAGE_ADDR: begin
                                if (cnt_q == 2'd2) begin
                                    page_start_d = clamp_page(byte_data_q);
                                end else begin
                                    page_end_d = clamp_page(byte_data_q);
                                    col_d      = col_start_q;
                                    page_d     = page_start_q;
                                end
                            end
`endif
                            default: ;
                        endcase
                        cnt_d = cnt_q - 2'd1;
                        if (cnt_q == 2'd1) state_d = DEC_OP;
                    end
                    default: state_d = DEC_OP;
                endcase
            end
        end
    end

    assign fb_waddr = AW'(int'(page_q) * COLS + int'(col_q));

    oled_rx_fb #(
        .DEPTH(FB_BYTES),
        .AW   (AW)
    ) u_fb (
        .clk_i  (clk),
        .we_i   (fb_we),
        .waddr_i(fb_waddr),
        .wdata_i(byte_data_q),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;
    assign display_on = disp_q;
    assign contrast   = contrast_q;

endmodule

// File: tb/tb_oled_rx.sv
// tb/tb_oled_rx.sv - self-checking bench for oled_rx with a byte-level behavioural model
module tb_oled_rx;

    localparam int NCOLS  = 128;
    localparam int NPAGES = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       oled_sck = 1'b1;
    logic       oled_mosi = 1'b0;
    logic       oled_dc = 1'b0;
    logic       oled_cs = 1'b1;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;
    logic       display_on;
    logic [7:0] contrast;

    oled_rx dut (
        .clk(clk), .rst_n(rst_n), .oled_sck(oled_sck), .oled_mosi(oled_mosi),
        .oled_dc(oled_dc), .oled_cs(oled_cs), .rd_addr(rd_addr), .rd_data(rd_data),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
        .display_on(display_on), .contrast(contrast)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    logic [8:0] exp_q [$];
    logic [7:0] fbm [1024];
    bit         fbw [1024];
    bit         m_disp;
    int         m_contrast, m_pend, m_op, m_argi;
    int         m_col, m_page, m_cs, m_ce, m_ps, m_pe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        m_disp = 0; m_contrast = 8'h7F; m_pend = 0; m_op = 0; m_argi = 0;
        m_col = 0; m_page = 0; m_cs = 0; m_ce = NCOLS - 1; m_ps = 0; m_pe = NPAGES - 1;
    endtask

    // Apply one received byte to the model using the controller's documented rules
    task automatic model_apply(input logic [7:0] b, input logic dc);
        int nargs;
        if (dc) begin
            fbm[m_page * NCOLS + m_col] = b;
            fbw[m_page * NCOLS + m_col] = 1'b1;
            if (m_col == m_ce) begin
                m_col = m_cs;
                m_page = (m_page == m_pe) ? m_ps : m_page + 1;
            end else begin
                m_col = m_col + 1;
            end
        end else if (m_pend == 0) begin
            if (b == 8'hAF) m_disp = 1;
            if (b == 8'hAE) m_disp = 0;
            nargs = 0;
            if (b inside {8'h20, 8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D}) nargs = 1;
            if (b inside {8'h21, 8'h22}) nargs = 2;
            m_pend = nargs; m_op = b; m_argi = 0;
        end else begin
            if (m_op == 8'h81) m_contrast = b;
`ifdef OLED_RX_ADDR_WINDOW_EN
            if (m_op == 8'h21) begin
                if (m_argi == 0) m_cs = clampi(b, NCOLS - 1);
                else begin m_ce = clampi(b, NCOLS - 1); m_col = m_cs; m_page = m_ps; end
            end
            if (m_op == 8'h22) begin
                if (m_argi == 0) m_ps = clampi(b, NPAGES - 1);
                else begin m_pe = clampi(b, NPAGES - 1); m_col = m_cs; m_page = m_ps; end
            end
`endif
            m_argi++;
            m_pend--;
        end
    endtask

    // Compare process: register outputs every cycle, then consume any byte strobe
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            model_reset();
        end else begin
            check("display_on", {31'd0, display_on}, {31'd0, m_disp});
            check("contrast", {24'd0, contrast}, m_contrast);
            if (byte_valid) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_data", {24'd0, byte_data}, {24'd0, e[7:0]});
                    check("byte_dc", {31'd0, byte_dc}, {31'd0, e[8]});
                    model_apply(e[7:0], e[8]);
                end
            end
        end
    end

    task automatic spi_bits(input logic [7:0] b, input logic dc, input int nbits);
        oled_cs = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            oled_sck = 1'b0; oled_mosi = b[i]; oled_dc = dc;
            repeat (2) @(negedge clk);
            oled_sck = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        exp_q.push_back({dc, b});
        spi_bits(b, dc, 8);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic read_fb(input int a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = 10'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    int         s0;
    logic [7:0] rd;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_byte_data", {24'd0, byte_data}, 32'h00);
        check("rst_byte_dc", {31'd0, byte_dc}, 32'd0);
        check("rst_display_on", {31'd0, display_on}, 32'd0);
        check("rst_contrast", {24'd0, contrast}, 32'h7F);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        s0 = strobes;
        send_byte(8'hAF, 1'b0);
        settle();
        check("af_display_on", {31'd0, display_on}, 32'd1);
        check("af_byte_data", {24'd0, byte_data}, 32'hAF);
        check("af_strobes", strobes - s0, 32'd1);

        send_byte(8'h81, 1'b0);
        send_byte(8'h3C, 1'b0);
        settle();
        check("contrast_3c", {24'd0, contrast}, 32'h3C);
        send_byte(8'hAE, 1'b0);
        settle();
        check("ae_as_opcode", {31'd0, display_on}, 32'd0);
        check("contrast_kept", {24'd0, contrast}, 32'h3C);

        s0 = strobes;
        spi_bits(8'h3C, 1'b0, 5);
        @(negedge clk); oled_cs = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'hA5, 1'b0);
        settle();
        check("cs_abort_byte", {24'd0, byte_data}, 32'hA5);
        check("cs_abort_strobes", strobes - s0, 32'd1);

        for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b1);
        settle();
        read_fb(0, rd);
        check("fb_000", {24'd0, rd}, 32'h00);
        read_fb(10'h3FF, rd);
        check("fb_3ff", {24'd0, rd}, 32'hFF);
        read_fb(10'h080, rd);
        check("fb_080", {24'd0, rd}, 32'h80);
        send_byte(8'h5A, 1'b1);
        settle();
        read_fb(0, rd);
        check("fb_wrap_000", {24'd0, rd}, 32'h5A);

        send_byte(8'h81, 1'b0);
        send_byte(8'h77, 1'b1);
        send_byte(8'h20, 1'b0);
        settle();
        check("contrast_after_data", {24'd0, contrast}, 32'h20);
        read_fb(1, rd);
        check("fb_mid_arg_data", {24'd0, rd}, 32'h77);

        send_byte(8'h21, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'hC1, 1'b1); send_byte(8'hC2, 1'b1); send_byte(8'hC3, 1'b1);
        settle();
`ifdef OLED_RX_ADDR_WINDOW_EN
        read_fb(10'h110, rd);
        check("win_110", {24'd0, rd}, 32'hC3);
        read_fb(10'h111, rd);
        check("win_111", {24'd0, rd}, 32'hC2);
`else
        read_fb(2, rd);
        check("nowin_002", {24'd0, rd}, 32'hC1);
        read_fb(4, rd);
        check("nowin_004", {24'd0, rd}, 32'hC3);
`endif

        send_byte(8'hAF, 1'b0);
        send_byte(8'h81, 1'b0);
        spi_bits(8'h12, 1'b0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_contrast", {24'd0, contrast}, 32'h7F);
        check("rst_mid_display", {31'd0, display_on}, 32'd0);
        check("rst_mid_byte_data", {24'd0, byte_data}, 32'h00);
        oled_cs = 1'b1; oled_sck = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'hAF, 1'b0);
        settle();
        check("post_rst_opcode", {31'd0, display_on}, 32'd1);
        check("post_rst_contrast", {24'd0, contrast}, 32'h7F);
        send_byte(8'h99, 1'b1);
        settle();
        read_fb(0, rd);
        check("post_rst_ptr", {24'd0, rd}, 32'h99);

        for (int a = 0; a < 1024; a++) begin
            if (fbw[a]) begin
                read_fb(a, rd);
                check("fb_sweep", {24'd0, rd}, {24'd0, fbm[a]});
            end
        end
        check("pending_strobes", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oled_rx.md
OLED_RX -- requirements
Module: oled_rx

Interface
REQ-001 SHALL have parameter FB_BYTES, default 1024; framebuffer depth in bytes (COLS*PAGES).
REQ-002 SHALL have parameter COLS, default 128; columns per page.
REQ-003 SHALL have parameter PAGES, default 8; pages, 8 pixel rows each.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port oled_sck  input  1  SPI clock; idle high; data sampled on rising edge.
REQ-007 SHALL have port oled_mosi  input  1  SPI data; MSB first.
REQ-008 SHALL have port oled_dc  input  1  0 = command byte, 1 = pixel data byte; sampled with the last bit.
REQ-009 SHALL have port oled_cs  input  1  active-low chip select.
REQ-010 SHALL have port rd_addr  input  10  framebuffer read address, page*COLS+col.
REQ-011 SHALL have port rd_data  output  8  framebuffer read data.
REQ-012 SHALL have port byte_valid  output  1  one-cycle strobe per received byte.
REQ-013 SHALL have port byte_data  output  8  last received byte; stable until the next strobe.
REQ-014 SHALL have port byte_dc  output  1  dc value of the last received byte.
REQ-015 SHALL have port display_on  output  1  set by 0xAF, cleared by 0xAE.
REQ-016 SHALL have port contrast  output  8  argument of the last 0x81 command.

Function
REQ-017 SHALL pass oled_sck, oled_mosi, oled_dc and oled_cs through 2-flop synchronizers; sck high time and sck low time SHALL each be at least 2 clk periods.
REQ-018 SHALL detect an sck rising edge as synced previous sample 0 and current sample 1 while cs is low, then shift mosi into an 8-bit register and increment a 3-bit bit counter.
REQ-019 SHALL, on the 8th bit, pulse byte_valid one cycle after that edge, latch byte_data and byte_dc, and clear the bit counter.
REQ-020 SHALL clear the bit counter and discard the partial byte whenever synced cs is high; decoder state is kept across cs deassertion.
REQ-021 SHALL run the command decoder with states DEC_OP (expect opcode) and DEC_ARG (remaining-argument count 1..2).
REQ-022 SHALL, in DEC_OP, treat these as 1-argument opcodes: 0x20, 0x81, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D.
REQ-023 SHALL treat 0x21 and 0x22 as 2-argument opcodes; every other opcode is single-byte and stays in DEC_OP.
REQ-024 SHALL, in DEC_ARG, route each command byte to the pending opcode's register, decrement the count, and return to DEC_OP at zero.
REQ-025 SHALL, for a data byte (dc=1), write it to the framebuffer at the current column/page pointer, regardless of decoder state; a pending argument count is unaffected.
REQ-026 SHALL advance the pointer after each write in horizontal mode (0x20 arg 0): col+1; at col_end, col=col_start and page+1; at page_end, page=page_start (wrap).
REQ-027 SHALL, for 0x20 argument other than 0, accept and store the value but keep the horizontal advance.
REQ-028 SHALL give rd_data one cycle of latency after rd_addr; a same-cycle write and read to one address returns the old data.

Reset
REQ-029 SHALL, on rst_n low, immediately clear: bit counter, shift register, byte_valid, byte_data, byte_dc, display_on, pointer (col 0, page 0), and decoder state (DEC_OP).
REQ-030 SHALL, on rst_n low, set contrast to 0x7F, col window to 0..COLS-1 and page window to 0..PAGES-1.
REQ-031 SHALL leave framebuffer contents unchanged by reset; reset mid-byte discards the partial byte.

Configuration
REQ-032 SHALL, with OLED_RX_ADDR_WINDOW_EN defined, load col_start/col_end from 0x21 and page_start/page_end from 0x22, reset the pointer to (col_start, page_start), and clamp out-of-range arguments to COLS-1 or PAGES-1.
REQ-033 SHALL, without OLED_RX_ADDR_WINDOW_EN, consume the 0x21/0x22 arguments, ignore them, and keep the full-screen window.

Structure
REQ-034 SHALL place opcode constants, argument-count lookup and decoder state encoding in package oled_pkg.
REQ-035 SHALL put the framebuffer in sub-module oled_rx_fb: 1 write port, 1 registered read port, FB_BYTES x 8.

Verification
REQ-036 SHALL cover: send command 0xAF with dc=0 -> display_on=1, one byte_valid with byte_data 0xAF.
REQ-037 SHALL cover: send 0x81, 0x3C -> contrast=0x3C; decoder back in DEC_OP.
REQ-038 SHALL cover: send 1024 data bytes with value index[7:0] -> rd_addr 0x000 reads 0x00, 0x3FF reads 0xFF; 1025th byte overwrites addr 0.
REQ-039 SHALL cover: raise cs after 5 bits, then send full byte 0xA5 -> byte_data=0xA5, exactly one strobe.
REQ-040 SHALL cover (macro on): 0x21,0x10,0x11 and 0x22,0x02,0x02, then 3 data bytes -> writes at 0x110, 0x111, 0x110.
REQ-041 SHALL cover: assert rst_n low mid-byte after 0x81 -> contrast=0x7F, DEC_OP, next byte decoded as opcode.
